// File: rtl/seq_engine_arb.sv
`default_nettype none
// ============================================================================
// Module      : seq_engine_arb
// Description : Two-requester round-robin scheduler driving the go/jmp
//               sequence engine, with jump-ack check, timeout and recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_engine_arb #(
    parameter int HW  = 4,
    parameter int TMO = 15,
    parameter int TW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [HW-1:0] hold0,
    input  logic [HW-1:0] hold1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          err,
    output logic          busy,
    output logic          eng_go,
    output logic          eng_jmp,
    output logic          eng_rst_n,
    input  logic          eng_y
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_GO     = 3'd1;
    localparam logic [2:0] c_HOLD   = 3'd2;
    localparam logic [2:0] c_JMP    = 3'd3;
    localparam logic [2:0] c_RUN    = 3'd4;
    localparam logic [2:0] c_SETTLE = 3'd5;
    localparam logic [2:0] c_ERR    = 3'd6;

    localparam logic [HW-1:0] c_CNT_ONE  = HW'(1);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TMO - 1);

    logic [2:0]    r_state, w_state_nxt;
    logic [HW-1:0] r_cnt, w_cnt_nxt;
    logic [TW-1:0] r_tmo, w_tmo_nxt;
    logic [1:0]    r_gnt, w_gnt_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_rr, w_rr_nxt;
    logic          w_win;

    // Only one requester: it wins. Both: the round-robin pointer decides.
    assign w_win = (req == 2'b11) ? r_rr : req[1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = r_tmo;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        case (r_state)
            c_IDLE: begin
                if (req != 2'b00) begin
                    w_owner_nxt = w_win;
                    w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
                    w_cnt_nxt   = w_win ? hold1 : hold0;
                    w_state_nxt = c_GO;
                end
            end
            c_GO: begin
                w_state_nxt = (r_cnt != '0) ? c_HOLD : c_JMP;
            end
            c_HOLD: begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = c_JMP;
                end
            end
            c_JMP: begin
                w_tmo_nxt = '0;
                if (eng_y) begin
                    w_state_nxt = c_RUN;
                end else begin
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = c_ERR;
                end
            end
            c_RUN: begin
                w_tmo_nxt = r_tmo + TW'(1);
                // End-of-sequence wins over a timeout landing in the same cycle.
                if (eng_y) begin
                    w_state_nxt = c_SETTLE;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = c_ERR;
                end
            end
            c_SETTLE: begin
                w_gnt_nxt   = 2'b00;
                w_rr_nxt    = ~r_owner;
                w_state_nxt = c_IDLE;
            end
            c_ERR: begin
                w_rr_nxt    = ~r_owner;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_gnt_nxt   = 2'b00;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_gnt   <= 2'b00;
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign done      = (r_state == c_SETTLE) ? r_gnt : 2'b00;
    assign err       = (r_state == c_ERR);
    assign busy      = (r_state != c_IDLE);
    assign eng_go    = (r_state == c_GO);
    assign eng_jmp   = (r_state == c_JMP);
    // Engine stays in reset for the whole block reset, not just one cycle.
    assign eng_rst_n = ~(rst | (r_state == c_ERR));

endmodule
`default_nettype wire

// File: tb/tb_seq_engine_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_engine_arb
// Description : Directed self-checking bench for seq_engine_arb with a
//               behavioural go/jmp engine model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_engine_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] hold0, hold1;
    logic [1:0] gnt, done;
    logic       err, busy, eng_go, eng_jmp, eng_rst_n, eng_y;

    int n_checks = 0;
    int n_fail   = 0;

    // Engine model knobs: acknowledge the jump, and end the sequence 6 cycles later.
    logic        ack_ok = 1'b1;
    logic        eos_ok = 1'b1;
    logic [15:0] k;

    seq_engine_arb #(.HW(4), .TMO(15), .TW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .hold0     (hold0),
        .hold1     (hold1),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .eng_go    (eng_go),
        .eng_jmp   (eng_jmp),
        .eng_rst_n (eng_rst_n),
        .eng_y     (eng_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!eng_rst_n)                 k <= 16'd0;
        else if (eng_jmp)               k <= 16'd1;
        else if (k != 0 && k < 16'd1000) k <= k + 16'd1;
    end

    assign eng_y = (eng_jmp & ack_ok) | ((k == 16'd6) & eos_ok);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst = 1'b1; req = 2'b00; hold0 = 4'd0; hold1 = 4'd0;
        tick(); tick();
        obs = {gnt, done, err, busy, eng_go, eng_jmp};
        n_checks++;
        if (obs !== 8'b0) begin
            n_fail++; $display("FAIL reset_outputs got %b want %b", obs, 8'b0);
        end
        n_checks++;
        if (eng_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL reset_eng_rst_n got %b want 0", eng_rst_n);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (eng_rst_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset got rst_n=%b busy=%b want 1 0", eng_rst_n, busy);
        end
    endtask

    // hold0=2: GO c0, HOLD c1-c2, JMP c3, RUN c4-c9, SETTLE c10.
    task automatic test_single();
        logic [6:0] obs, exp_v;
        req = 2'b01; hold0 = 4'd2;
        tick();
        req = 2'b00; hold0 = 4'd7;
        for (int c = 0; c < 11; c++) begin
            exp_v = {2'b01, (c == 10) ? 2'b01 : 2'b00, 1'b0, c == 0, c == 3};
            obs   = {gnt, done, err, eng_go, eng_jmp};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL single c=%0d got %b want %b", c, obs, exp_v);
            end
            tick();
        end
        n_checks++;
        if ({gnt, done, err, busy} !== 6'b0) begin
            n_fail++; $display("FAIL single_idle got %b want 000000", {gnt, done, err, busy});
        end
    endtask

    // hold0=0: GO c0, JMP c1, RUN c2-c7, SETTLE c8.
    task automatic test_zero_hold();
        logic [6:0] obs, exp_v;
        req = 2'b01; hold0 = 4'd0;
        tick();
        req = 2'b00;
        for (int c = 0; c < 9; c++) begin
            exp_v = {2'b01, (c == 8) ? 2'b01 : 2'b00, 1'b0, c == 0, c == 1};
            obs   = {gnt, done, err, eng_go, eng_jmp};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL zero_hold c=%0d got %b want %b", c, obs, exp_v);
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_hold_idle got busy=%b want 0", busy);
        end
    endtask

    // hold=1 runs take 10 cycles plus one IDLE cycle; grants alternate from 01.
    task automatic test_back_to_back();
        logic [4:0] obs, exp_v;
        logic [1:0] g;
        rst = 1'b1; req = 2'b11; hold0 = 4'd1; hold1 = 4'd1;
        tick();
        rst = 1'b0;
        tick();
        for (int r = 0; r < 4; r++) begin
            g = r[0] ? 2'b10 : 2'b01;
            for (int c = 0; c < 11; c++) begin
                exp_v = {(c < 10) ? g : 2'b00, (c == 9) ? g : 2'b00, c < 10};
                obs   = {gnt, done, busy};
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++; $display("FAIL back_to_back r=%0d c=%0d got %b want %b", r, c, obs, exp_v);
                end
                if (r == 3 && c == 10) req = 2'b00;
                tick();
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL back_to_back_end got busy=%b want 0", busy);
        end
    endtask

    // No jump-ack: GO c0, JMP c1, ERR c2, IDLE c3; then requester 1 wins.
    task automatic test_missing_ack();
        logic [6:0] obs, exp_v;
        ack_ok = 1'b0; req = 2'b01; hold0 = 4'd0;
        tick();
        req = 2'b00;
        for (int c = 0; c < 4; c++) begin
            exp_v = {(c < 2) ? 2'b01 : 2'b00, 2'b00, c == 2, c != 2, c < 3};
            obs   = {gnt, done, err, eng_rst_n, busy};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL missing_ack c=%0d got %b want %b", c, obs, exp_v);
            end
            tick();
        end
        ack_ok = 1'b1; req = 2'b11; hold0 = 4'd0; hold1 = 4'd0;
        tick();
        req = 2'b00;
        for (int c = 0; c < 9; c++) begin
            exp_v = {2'b10, (c == 8) ? 2'b10 : 2'b00, 1'b0, 1'b1, 1'b1};
            obs   = {gnt, done, err, eng_rst_n, busy};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL after_err c=%0d got %b want %b", c, obs, exp_v);
            end
            tick();
        end
    endtask

    // No end-of-sequence: JMP c1, RUN c2-c16, ERR c17, IDLE c18.
    task automatic test_timeout();
        logic [5:0] obs, exp_v;
        eos_ok = 1'b0; req = 2'b01; hold0 = 4'd0;
        tick();
        req = 2'b00;
        for (int c = 0; c < 19; c++) begin
            exp_v = {(c <= 16) ? 2'b01 : 2'b00, 2'b00, c == 17, c <= 17};
            obs   = {gnt, done, err, busy};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL timeout c=%0d got %b want %b", c, obs, exp_v);
            end
            tick();
        end
        eos_ok = 1'b1;
    endtask

    // hold1=3: GO c0, HOLD c1-c3, JMP c4, RUN from c5; reset hits at c6.
    task automatic test_mid_reset();
        logic [6:0] obs, exp_v;
        req = 2'b10; hold1 = 4'd3;
        tick();
        req = 2'b00;
        for (int c = 0; c < 7; c++) begin
            exp_v = {2'b10, 2'b00, 1'b0, c == 0, c == 4};
            obs   = {gnt, done, err, eng_go, eng_jmp};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL mid_pre c=%0d got %b want %b", c, obs, exp_v);
            end
            if (c < 6) tick();
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (eng_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_n got %b want 0", eng_rst_n);
        end
        tick();
        n_checks++;
        if ({gnt, done, err, busy, eng_go, eng_jmp, eng_rst_n} !== 9'b0) begin
            n_fail++; $display("FAIL mid_cleared got %b want 000000000",
                               {gnt, done, err, busy, eng_go, eng_jmp, eng_rst_n});
        end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_checks++;
            if ({done, err, busy, eng_rst_n} !== 5'b00001) begin
                n_fail++; $display("FAIL mid_quiet c=%0d got %b want 00001", c, {done, err, busy, eng_rst_n});
            end
            tick();
        end
        // Pointer is back to 0 after reset, so a both-request picks requester 0.
        req = 2'b11; hold0 = 4'd1; hold1 = 4'd1;
        tick();
        req = 2'b00;
        for (int c = 0; c < 10; c++) begin
            exp_v = {2'b01, (c == 9) ? 2'b01 : 2'b00, 1'b0, c == 0, c == 2};
            obs   = {gnt, done, err, eng_go, eng_jmp};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL mid_fresh c=%0d got %b want %b", c, obs, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_hold();
        test_back_to_back();
        test_missing_ack();
        test_timeout();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
